// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Imported by the top and by the two-way picker.
package dmem_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way picker producing a one-hot grant.
// Round-robin against last_served, or strict port-0 priority when FIXED_PRIO=1.
module rr_arbiter2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       req0,
    input  logic       req1,
    input  logic       last_served,
    output logic [1:0] gnt
);
    import dmem_pkg::*;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        gnt = 2'b00;
        if (req0 && req1) begin
            if (FIXED_PRIO || (last_served == PORT1)) gnt = 2'b01;
            else                                      gnt = 2'b10;
        end else begin
            gnt = {req1, req0};
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data memory.
// Each access takes one IDLE grant cycle plus one ACCESS cycle; ack follows ACCESS.
module data_memory_arbiter #(
    parameter int ADDR_W     = dmem_pkg::ADDR_W,
    parameter int DATA_W     = dmem_pkg::DATA_W,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_d_in,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_d_out,
    output logic              busy
);
    import dmem_pkg::*;

    state_e            state_q, state_d;
    logic              last_served_q, last_served_d;
    logic              owner_q, owner_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_d_in_q, mem_d_in_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [1:0]        pick;

    rr_arbiter2 #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_served (last_served_q),
        .gnt         (pick)
    );

    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        owner_d       = owner_q;
        mem_addr_d    = mem_addr_q;
        mem_d_in_d    = mem_d_in_q;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
        mem_wr_d      = 1'b0;
        gnt0_d        = 1'b0;
        gnt1_d        = 1'b0;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick != 2'b00) begin
                    state_d       = ACCESS;
                    owner_d       = pick[1] ? PORT1 : PORT0;
                    last_served_d = pick[1] ? PORT1 : PORT0;
                    mem_wr_d      = pick[1] ? we1    : we0;
                    mem_addr_d    = pick[1] ? addr1  : addr0;
                    mem_d_in_d    = pick[1] ? wdata1 : wdata0;
                    gnt0_d        = pick[0];
                    gnt1_d        = pick[1];
                end
            end
            ACCESS: begin
                // mem_wr_q still carries the latched we here; it clears on the way out.
                state_d = IDLE;
                if (owner_q == PORT1) begin
                    ack1_d = 1'b1;
                    if (!mem_wr_q) rdata1_d = mem_d_out;
                end else begin
                    ack0_d = 1'b1;
                    if (!mem_wr_q) rdata0_d = mem_d_out;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_served_q <= PORT1;
            owner_q       <= PORT0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_d_in_q    <= '0;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            owner_q       <= owner_d;
            mem_wr_q      <= mem_wr_d;
            mem_addr_q    <= mem_addr_d;
            mem_d_in_q    <= mem_d_in_d;
            gnt0_q        <= gnt0_d;
            gnt1_q        <= gnt1_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign mem_addr = mem_addr_q;
    assign mem_d_in = mem_d_in_q;
    assign mem_wr   = mem_wr_q;
    assign busy     = (state_q == ACCESS);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a behavioural 32x16 memory,
// a scoreboard of expected completions, and a fixed-priority second instance.
module tb_data_memory_arbiter;

    typedef struct {
        logic        port;
        logic        is_write;
        logic [15:0] data;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [4:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, ack0, ack1, mem_wr, busy;
    logic [15:0] rdata0, rdata1, mem_d_in, mem_d_out;
    logic [4:0]  mem_addr;

    logic        fp_req0, fp_req1;
    logic        fp_gnt0, fp_gnt1, fp_ack0, fp_ack1, fp_mem_wr, fp_busy;
    logic [15:0] fp_rdata0, fp_rdata1, fp_mem_d_in, fp_mem_d_out;
    logic [4:0]  fp_mem_addr;

    logic [15:0] mem    [32];
    logic [15:0] fp_mem [32];
    logic        mem_loaded = 1'b0;
    logic        fp_loaded  = 1'b0;
    logic [15:0] ref_mem [32];
    logic [15:0] hold [2];
    sb_t         sb_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] init_word(input int i);
        return 16'h1000 + 16'(i) * 16'h0101;
    endfunction

    data_memory_arbiter #(.FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_d_in(mem_d_in), .mem_wr(mem_wr),
        .mem_d_out(mem_d_out), .busy(busy)
    );

    data_memory_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0(fp_req0), .req1(fp_req1), .we0(1'b0), .we1(1'b0),
        .addr0(5'd3), .addr1(5'd4), .wdata0(16'h0000), .wdata1(16'h0000),
        .gnt0(fp_gnt0), .gnt1(fp_gnt1), .ack0(fp_ack0), .ack1(fp_ack1),
        .rdata0(fp_rdata0), .rdata1(fp_rdata1),
        .mem_addr(fp_mem_addr), .mem_d_in(fp_mem_d_in), .mem_wr(fp_mem_wr),
        .mem_d_out(fp_mem_d_out), .busy(fp_busy)
    );

    // Memory models: combinational read, posedge write, preloaded on the first edge.
    assign mem_d_out    = mem[mem_addr];
    assign fp_mem_d_out = fp_mem[fp_mem_addr];

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (mem_wr) begin
            mem[mem_addr] <= mem_d_in;
        end
    end

    always @(posedge clk) begin
        if (!fp_loaded) begin
            for (int i = 0; i < 32; i++) fp_mem[i] <= init_word(i);
            fp_loaded <= 1'b1;
        end else if (fp_mem_wr) begin
            fp_mem[fp_mem_addr] <= fp_mem_d_in;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Completion monitor: every ack must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold[0] = 16'h0000;
            hold[1] = 16'h0000;
        end else begin
            check("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
            check("ack_exclusive", {31'd0, ack0 & ack1}, 32'd0);
            if (ack0 || ack1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    check("ack_port", {31'd0, ack1}, {31'd0, e.port});
                    if (!e.is_write) hold[e.port] = e.data;
                    check("rdata_winner", e.port ? rdata1 : rdata0, hold[e.port]);
                    check("rdata_loser", e.port ? rdata0 : rdata1, hold[~e.port]);
                end
            end
        end
    end

    task automatic drive(input logic p, input logic w, input logic [4:0] a, input logic [15:0] d);
        if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    endtask

    task automatic expect_done(input logic p, input logic w, input logic [4:0] a, input logic [15:0] d);
        sb_t e;
        e.port = p; e.is_write = w; e.data = w ? d : ref_mem[a];
        if (w) ref_mem[a] = d;
        sb_q.push_back(e);
    endtask

    // One complete access on a single port, checking the ACCESS-cycle memory drive.
    task automatic single(input logic p, input logic w, input logic [4:0] a, input logic [15:0] d);
        bit seen = 1'b0;
        drive(p, w, a, d);
        expect_done(p, w, a, d);
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            if (p ? gnt1 : gnt0) begin
                seen = 1'b1;
                check("access_busy", {31'd0, busy}, 32'd1);
                check("access_mem_wr", {31'd0, mem_wr}, {31'd0, w});
                check("access_mem_addr", {27'd0, mem_addr}, {27'd0, a});
                if (w) check("access_mem_d_in", {16'd0, mem_d_in}, {16'd0, d});
                if (p) req1 = 1'b0; else req0 = 1'b0;
            end
        end
        if (!seen) begin
            check("gnt_timeout", 32'd0, 32'd1);
            req0 = 1'b0; req1 = 1'b0;
        end
        @(negedge clk);
        check("ack_cycle_idle_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("ack_cycle_addr_hold", {27'd0, mem_addr}, {27'd0, a});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int g0, g1, cnt0, cnt1;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        fp_req0 = 1'b0; fp_req1 = 1'b0;
        for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_outputs", {gnt0, gnt1, ack0, ack1, mem_wr, busy}, 32'd0);
        check("rst_rdata", {rdata0, rdata1}, 32'd0);
        check("rst_mem_bus", {11'd0, mem_addr, mem_d_in}, 32'd0);
        rst_n = 1'b1;

        // Fixed priority: both ports request continuously for 20 cycles
        fp_req0 = 1'b1; fp_req1 = 1'b1;
        cnt0 = 0; cnt1 = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (fp_gnt0) cnt0++;
            if (fp_gnt1) cnt1++;
        end
        fp_req0 = 1'b0; fp_req1 = 1'b0;
        check("fp_gnt0_count", 32'(cnt0), 32'd10);
        check("fp_gnt1_count", 32'(cnt1), 32'd0);
        check("fp_rdata0", {16'd0, fp_rdata0}, {16'd0, init_word(3)});
        check("fp_rdata1", {16'd0, fp_rdata1}, 32'd0);

        // Port0 write then read-back
        single(1'b0, 1'b1, 5'd1, 16'h000F);
        single(1'b0, 1'b0, 5'd1, 16'h0000);
        check("readback_addr1", {16'd0, rdata0}, 32'h0000_000F);
        single(1'b1, 1'b0, 5'd9, 16'h0000);

        // Simultaneous reads after reset: port0 first, port1 two cycles later
        do_reset();
        drive(1'b0, 1'b0, 5'd0, 16'h0000);
        drive(1'b1, 1'b0, 5'd1, 16'h0000);
        expect_done(1'b0, 1'b0, 5'd0, 16'h0000);
        expect_done(1'b1, 1'b0, 5'd1, 16'h0000);
        g0 = -1; g1 = -1;
        for (int c = 1; c <= 10 && (g0 < 0 || g1 < 0); c++) begin
            @(negedge clk);
            if (gnt0) begin g0 = c; req0 = 1'b0; end
            if (gnt1) begin g1 = c; req1 = 1'b0; end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("both_gnt0_cycle", 32'(g0), 32'd1);
        check("both_gnt1_cycle", 32'(g1), 32'd3);
        repeat (2) @(negedge clk);

        // Port1 request raised while port0 is in ACCESS
        drive(1'b0, 1'b0, 5'd5, 16'h0000);
        expect_done(1'b0, 1'b0, 5'd5, 16'h0000);
        g0 = -1; g1 = -1;
        for (int c = 1; c <= 10 && g1 < 0; c++) begin
            @(negedge clk);
            if (gnt0) begin
                g0 = c; req0 = 1'b0;
                drive(1'b1, 1'b0, 5'd6, 16'h0000);
                expect_done(1'b1, 1'b0, 5'd6, 16'h0000);
            end
            if (gnt1) begin g1 = c; req1 = 1'b0; end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("late_gnt0_cycle", 32'(g0), 32'd1);
        check("late_gnt1_cycle", 32'(g1), 32'd3);
        repeat (2) @(negedge clk);
        check("late_rdata0", {16'd0, rdata0}, {16'd0, init_word(5)});
        check("late_rdata1", {16'd0, rdata1}, {16'd0, init_word(6)});

        // Reset pulsed during ACCESS of a port1 write to addr 31
        drive(1'b1, 1'b1, 5'd31, 16'hABCD);
        g1 = -1;
        for (int c = 1; c <= 8 && g1 < 0; c++) begin
            @(negedge clk);
            if (gnt1) g1 = c;
        end
        req1 = 1'b0; we1 = 1'b0;
        check("rst_mid_gnt1_seen", 32'(g1), 32'd1);
        check("rst_mid_mem_wr_before", {31'd0, mem_wr}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_mem_wr_async", {31'd0, mem_wr}, 32'd0);
        check("rst_mid_busy_async", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_addr31_kept", {16'd0, mem[31]}, {16'd0, init_word(31)});
        check("rst_mid_no_ack", {30'd0, ack1, ack0}, 32'd0);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
